// File: rtl/hls_prim_units_if.sv
// Signal bundle for hls_prim_units: adder operands/results, phi selection inputs/results
// and the last-block commit strobe. All signals are free-running; no handshake exists.
interface hls_prim_units_if #(
  parameter int ADD_WIDTH = 32,
  parameter int PHI_WIDTH = 8,
  parameter int NB_PAIR   = 2
);
  logic [ADD_WIDTH-1:0]         add_in0;
  logic [ADD_WIDTH-1:0]         add_in1;
  logic [ADD_WIDTH-1:0]         add_out;
  logic [ADD_WIDTH-1:0]         add_out_q;
  logic [NB_PAIR*PHI_WIDTH-1:0] phi_in;
  logic [NB_PAIR*32-1:0]        phi_s;
  logic [31:0]                  bb_id;
  logic                         bb_commit;
  logic [31:0]                  last_block;
  logic [PHI_WIDTH-1:0]         phi_out;
  logic                         phi_hit;
  logic [PHI_WIDTH-1:0]         phi_out_q;

  // Inputs are sampled every cycle; there is no valid/ready pairing on this bundle.
  modport slave (
    input  add_in0, add_in1, phi_in, phi_s, bb_id, bb_commit,
    output add_out, add_out_q, last_block, phi_out, phi_hit, phi_out_q
  );

  modport master (
    output add_in0, add_in1, phi_in, phi_s, bb_id, bb_commit,
    input  add_out, add_out_q, last_block, phi_out, phi_hit, phi_out_q
  );
endinterface

// File: rtl/hls_prim_units.sv
// HLS primitive units: wrapping adder, an empty port-less branch unit and a phi selector
// driven by a registered last-block id, each with a registered copy of its result.
module hls_add #(
  parameter int W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o
);
  assign sum_o = a_i + b_i;
endmodule

module hls_br_dummy;
endmodule

module hls_phi #(
  parameter int PW = 8,
  parameter int NB = 2
) (
  input  logic [NB*PW-1:0] in_i,
  input  logic [NB*32-1:0] s_i,
  input  logic [31:0]      last_block_i,
  output logic [PW-1:0]    out_o,
  output logic             hit_o
);
  // Scan from the top index down so the lowest matching index wins.
  always_comb begin
    out_o = '0;
    hit_o = 1'b0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (s_i[i*32 +: 32] == last_block_i) begin
        out_o = in_i[i*PW +: PW];
        hit_o = 1'b1;
      end
    end
  end
endmodule

module hls_prim_units #(
  parameter int ADD_WIDTH = 32,
  parameter int PHI_WIDTH = 8,
  parameter int NB_PAIR   = 2
) (
  input  logic             clk,
  input  logic             rst,
  hls_prim_units_if.slave  bus
);
  logic [ADD_WIDTH-1:0] add_sum;
  logic [PHI_WIDTH-1:0] phi_val;
  logic                 phi_hit;

  logic [31:0]          last_block_q, last_block_d;
  logic [ADD_WIDTH-1:0] add_sum_q;
  logic [PHI_WIDTH-1:0] phi_val_q;

  hls_add #(.W(ADD_WIDTH)) u_add (
    .a_i   (bus.add_in0),
    .b_i   (bus.add_in1),
    .sum_o (add_sum)
  );

  hls_br_dummy u_br_dummy ();

  // Phi looks at the registered id, so a commit is visible one cycle later.
  hls_phi #(.PW(PHI_WIDTH), .NB(NB_PAIR)) u_phi (
    .in_i         (bus.phi_in),
    .s_i          (bus.phi_s),
    .last_block_i (last_block_q),
    .out_o        (phi_val),
    .hit_o        (phi_hit)
  );

  always_comb begin
    last_block_d = last_block_q;
    if (bus.bb_commit) last_block_d = bus.bb_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_block_q <= '0;
      add_sum_q    <= '0;
      phi_val_q    <= '0;
    end else begin
      last_block_q <= last_block_d;
      add_sum_q    <= add_sum;
      phi_val_q    <= phi_val;
    end
  end

  assign bus.add_out    = add_sum;
  assign bus.add_out_q  = add_sum_q;
  assign bus.phi_out    = phi_val;
  assign bus.phi_hit    = phi_hit;
  assign bus.phi_out_q  = phi_val_q;
  assign bus.last_block = last_block_q;
endmodule

// File: tb/tb_hls_prim_units.sv
// Bench for hls_prim_units: directed vector table, hand-written reset/latency
// sequences and randomized traffic against an arithmetic reference model.
module tb_hls_prim_units;
  localparam int AW = 32;
  localparam int PW = 8;
  localparam int NB = 2;

  typedef struct {
    logic [AW-1:0]    a;
    logic [AW-1:0]    b;
    logic [NB*PW-1:0] phi_in;
    logic [NB*32-1:0] phi_s;
    logic [31:0]      commit_id;
    logic [AW-1:0]    exp_sum;
    logic [PW-1:0]    exp_phi;
    logic             exp_hit;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [AW-1:0] exp_add_q[$];
  logic [PW-1:0] exp_phi_q[$];
  logic [31:0]   model_last;

  hls_prim_units_if #(.ADD_WIDTH(AW), .PHI_WIDTH(PW), .NB_PAIR(NB)) bus ();

  hls_prim_units #(.ADD_WIDTH(AW), .PHI_WIDTH(PW), .NB_PAIR(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic commit(input logic [31:0] id);
    bus.bb_id     = id;
    bus.bb_commit = 1'b1;
    tick();
    bus.bb_commit = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [PW:0] ref_phi(input logic [NB*PW-1:0] vals,
                                          input logic [NB*32-1:0] ids,
                                          input logic [31:0] last);
    logic [31:0] id_q[$];
    int          idx[$];
    for (int i = 0; i < NB; i++) id_q.push_back(ids[i*32 +: 32]);
    idx = id_q.find_first_index(x) with (x == last);
    if (idx.size() == 0) return '0;
    return {1'b1, vals[idx[0]*PW +: PW]};
  endfunction

  // ---------------- test ----------------
  vec_t vecs[4];

  initial begin
    logic [PW:0]   r;
    logic [AW-1:0] s;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{32'h1, 32'h2, 16'hABCD, 64'h00000005_00000004, 32'd4, 32'h3, 8'hCD, 1'b1};
    vecs[1] = '{32'h80000000, 32'h80000000, 16'hABCD, 64'h00000005_00000004, 32'd5, 32'h0, 8'hAB, 1'b1};
    vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 16'hABCD, 64'h00000009_00000009, 32'd9, 32'hFFFFFFFE, 8'hCD, 1'b1};
    vecs[3] = '{32'h12345678, 32'h11111111, 16'hABCD, 64'h00000009_00000009, 32'd6, 32'h23456789, 8'h00, 1'b0};

    rst = 1'b1;
    bus.add_in0 = 32'd5; bus.add_in1 = 32'd6;
    bus.phi_in = '0; bus.phi_s = '1; bus.bb_id = '0; bus.bb_commit = 1'b0;
    #1;
    chk("reset_last_block", bus.last_block, 0);
    chk("reset_add_out_q", bus.add_out_q, 0);
    chk("reset_phi_out_q", bus.phi_out_q, 0);
    chk("comb_add_in_reset", bus.add_out, 32'd11);
    tick();
    rst = 1'b0;
    tick();
    chk("add_q_latency", bus.add_out_q, 32'd11);

    // Scenario 1: adder wrap
    bus.add_in0 = 32'hFFFFFFFF; bus.add_in1 = 32'h1;
    #1;
    chk("wrap_add_out", bus.add_out, 0);
    tick();
    chk("wrap_add_out_q", bus.add_out_q, 0);

    // Scenario 2: select after reset
    rst = 1'b1; #1; rst = 1'b0;
    bus.phi_in = 16'h5A00; bus.phi_s = 64'h00000001_00000000;
    #1;
    chk("s2_last_block", bus.last_block, 0);
    chk("s2_phi_out", bus.phi_out, 8'h00);
    chk("s2_phi_hit", bus.phi_hit, 1);

    // Scenario 3: commit latency
    tick();
    bus.bb_id = 32'd1; bus.bb_commit = 1'b1;
    #1;
    chk("s3_before_edge", bus.phi_out, 8'h00);
    tick();
    bus.bb_commit = 1'b0;
    chk("s3_last_block", bus.last_block, 1);
    chk("s3_phi_out", bus.phi_out, 8'h5A);
    chk("s3_phi_out_q_old", bus.phi_out_q, 8'h00);
    tick();
    chk("s3_phi_out_q", bus.phi_out_q, 8'h5A);

    // Scenario 4: no match
    commit(32'd7);
    #1;
    chk("s4_phi_out", bus.phi_out, 0);
    chk("s4_phi_hit", bus.phi_hit, 0);

    // Scenario 5: duplicate ids, lowest index wins
    commit(32'd3);
    bus.phi_s = 64'h00000003_00000003; bus.phi_in = 16'h1122;
    #1;
    chk("s5_phi_out", bus.phi_out, 8'h22);

    // Scenario 6: asynchronous reset mid-cycle, commit ignored during reset
    commit(32'd1);
    bus.phi_s = 64'h00000001_00000000; bus.phi_in = 16'h5A00;
    bus.add_in0 = 32'd40; bus.add_in1 = 32'd2;
    tick();
    chk("s6_pre_phi_q", bus.phi_out_q, 8'h5A);
    chk("s6_pre_add_q", bus.add_out_q, 32'd42);
    #2;
    rst = 1'b1; bus.bb_id = 32'd9; bus.bb_commit = 1'b1;
    #1;
    chk("s6_async_last_block", bus.last_block, 0);
    chk("s6_async_add_q", bus.add_out_q, 0);
    chk("s6_async_phi_q", bus.phi_out_q, 0);
    chk("s6_comb_add", bus.add_out, 32'd42);
    tick();
    chk("s6_commit_ignored", bus.last_block, 0);
    rst = 1'b0; bus.bb_commit = 1'b0;

    // Directed vector table
    for (int v = 0; v < 4; v++) begin
      commit(vecs[v].commit_id);
      bus.add_in0 = vecs[v].a; bus.add_in1 = vecs[v].b;
      bus.phi_in = vecs[v].phi_in; bus.phi_s = vecs[v].phi_s;
      #1;
      chk($sformatf("vec%0d_add_out", v), bus.add_out, vecs[v].exp_sum);
      chk($sformatf("vec%0d_phi_out", v), bus.phi_out, vecs[v].exp_phi);
      chk($sformatf("vec%0d_phi_hit", v), bus.phi_hit, vecs[v].exp_hit);
      tick();
      chk($sformatf("vec%0d_add_out_q", v), bus.add_out_q, vecs[v].exp_sum);
      chk($sformatf("vec%0d_phi_out_q", v), bus.phi_out_q, vecs[v].exp_phi);
    end

    // Randomized traffic against the model
    commit(32'd0);
    model_last = 32'd0;
    for (int n = 0; n < 300; n++) begin
      bus.add_in0 = $urandom;
      bus.add_in1 = (n % 8 == 0) ? (~bus.add_in0 + 32'd1) : $urandom;
      bus.phi_in  = NB*PW'($urandom);
      for (int i = 0; i < NB; i++) bus.phi_s[i*32 +: 32] = $urandom_range(0, 3);
      bus.bb_id     = $urandom_range(0, 3);
      bus.bb_commit = ($urandom_range(0, 2) == 0);
      #1;
      s = bus.add_in0 + bus.add_in1;
      r = ref_phi(bus.phi_in, bus.phi_s, model_last);
      chk("rnd_add_out", bus.add_out, s);
      chk("rnd_phi_out", bus.phi_out, r[PW-1:0]);
      chk("rnd_phi_hit", bus.phi_hit, r[PW]);
      exp_add_q.push_back(s);
      exp_phi_q.push_back(r[PW-1:0]);
      if (bus.bb_commit) model_last = bus.bb_id;
      tick();
      chk("rnd_add_out_q", bus.add_out_q, exp_add_q.pop_front());
      chk("rnd_phi_out_q", bus.phi_out_q, exp_phi_q.pop_front());
      chk("rnd_last_block", bus.last_block, model_last);
    end
    bus.bb_commit = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
